// File: rtl/bip_program_memory_loadable_if.sv
// Fetch and byte-stream load port bundle for the loadable BIP program memory.
// The control unit and UART loader sit on the master side; the memory is the slave.
interface bip_program_memory_loadable_if #(
    parameter int NB_DATA            = 16,
    parameter int LOG2_N_INSMEM_ADDR = 11,
    parameter int NB_BYTE            = 8
);
    logic                          i_enable;
    logic [LOG2_N_INSMEM_ADDR-1:0] i_addr;
    logic [NB_DATA-1:0]            o_data;
    logic                          o_data_valid;
    logic                          i_load_start;
    logic [NB_BYTE-1:0]            i_byte;
    logic                          i_byte_valid;
    logic                          o_loaded;
    logic [LOG2_N_INSMEM_ADDR:0]   o_prog_len;
    logic                          o_overflow;

    modport master (
        output i_enable, i_addr, i_load_start, i_byte, i_byte_valid,
        input  o_data, o_data_valid, o_loaded, o_prog_len, o_overflow
    );

    modport slave (
        input  i_enable, i_addr, i_load_start, i_byte, i_byte_valid,
        output o_data, o_data_valid, o_loaded, o_prog_len, o_overflow
    );
endinterface

// File: rtl/bip_program_memory_loadable.sv
// BIP instruction memory loaded at run time from a byte stream; fetch is enabled once
// a program terminated by a halt word (opcode 0) has been stored.
module bip_program_memory_loadable #(
    parameter int NB_DATA            = 16,
    parameter int N_ADDR             = 2048,
    parameter int LOG2_N_INSMEM_ADDR = 11,
    parameter int NB_BYTE            = 8,
    parameter int NB_OPCODE          = 5
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    bip_program_memory_loadable_if.slave bus
);
    localparam int NB_WORD_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_BCNT       = (NB_WORD_BYTES > 1) ? $clog2(NB_WORD_BYTES) : 1;
    localparam int NB_LEN        = LOG2_N_INSMEM_ADDR + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

    state_t                        state, next_state;
    logic [NB_DATA-1:0]            mem [N_ADDR];
    logic [NB_BCNT-1:0]            byte_cnt;
    logic [LOG2_N_INSMEM_ADDR-1:0] wr_ptr;
    logic [NB_DATA-1:0]            asm_word;
    logic [NB_DATA-1:0]            wr_word;
    logic [NB_LEN-1:0]             prog_len;
    logic                          loaded;
    logic                          overflow;
    logic [NB_DATA-1:0]            rd_data;
    logic                          rd_valid;
    logic                          byte_take;
    logic                          last_byte;
    logic                          word_done;
    logic                          is_halt;
    logic                          at_last;
    logic                          fetch_en;

    // A start pulse has priority over a byte arriving in the same cycle.
    assign byte_take = (state == ST_LOAD) && bus.i_byte_valid && !bus.i_load_start;
    assign last_byte = (byte_cnt == NB_BCNT'(NB_WORD_BYTES - 1));
    assign word_done = byte_take && last_byte;
    assign is_halt   = (wr_word[NB_DATA-1 -: NB_OPCODE] == '0);
    assign at_last   = (wr_ptr == LOG2_N_INSMEM_ADDR'(N_ADDR - 1));
    assign fetch_en  = (state == ST_RUN) && !bus.i_load_start && bus.i_enable;

    // Incoming byte merged into its little-endian lane of the assembly register.
    always_comb begin
        wr_word = asm_word;
        for (int k = 0; k < NB_WORD_BYTES; k++) begin
            if (byte_cnt == NB_BCNT'(k))
                wr_word[k*NB_BYTE +: NB_BYTE] = bus.i_byte;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (bus.i_load_start)
            next_state = ST_LOAD;
        else if (word_done) begin
            if (is_halt)      next_state = ST_RUN;
            else if (at_last) next_state = ST_IDLE;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            byte_cnt <= '0;
            wr_ptr   <= '0;
            asm_word <= '0;
            prog_len <= '0;
            loaded   <= 1'b0;
            overflow <= 1'b0;
        end else if (bus.i_load_start) begin
            byte_cnt <= '0;
            wr_ptr   <= '0;
            asm_word <= '0;
            prog_len <= '0;
            loaded   <= 1'b0;
            overflow <= 1'b0;
        end else if (byte_take) begin
            if (last_byte) begin
                byte_cnt <= '0;
                asm_word <= '0;
                wr_ptr   <= wr_ptr + 1'b1;
                if (is_halt) begin
                    loaded   <= 1'b1;
                    prog_len <= {1'b0, wr_ptr} + 1'b1;
                end else if (at_last) begin
                    overflow <= 1'b1;
                    prog_len <= NB_LEN'(N_ADDR);
                end
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
                asm_word <= wr_word;
            end
        end
    end

    // Storage is not reset so that it maps onto block RAM.
    always_ff @(posedge i_clock) begin
        if (i_reset && word_done)
            mem[wr_ptr] <= wr_word;
    end

    // Addresses past the loaded program read back as halt.
    always_ff @(posedge i_clock) begin
        if (!i_reset || (state != ST_RUN) || bus.i_load_start) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (fetch_en) begin
            rd_data  <= ({1'b0, bus.i_addr} < prog_len) ? mem[bus.i_addr] : '0;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

    assign bus.o_data       = rd_data;
    assign bus.o_data_valid = rd_valid;
    assign bus.o_loaded     = loaded;
    assign bus.o_prog_len   = prog_len;
    assign bus.o_overflow   = overflow;
endmodule

// File: tb/tb_bip_program_memory_loadable.sv
// Directed bench for the loadable BIP program memory, built with an 8-word memory
// so the full/overflow boundary is reachable.
module tb_bip_program_memory_loadable;
    localparam int NB_DATA = 16;
    localparam int N_ADDR  = 8;
    localparam int LOG2_A  = 3;
    localparam int NB_BYTE = 8;

    logic i_clock;
    logic i_reset;
    int   n_checks;
    int   n_errors;

    bip_program_memory_loadable_if #(
        .NB_DATA(NB_DATA), .LOG2_N_INSMEM_ADDR(LOG2_A), .NB_BYTE(NB_BYTE)
    ) bus ();

    bip_program_memory_loadable #(
        .NB_DATA(NB_DATA), .N_ADDR(N_ADDR), .LOG2_N_INSMEM_ADDR(LOG2_A),
        .NB_BYTE(NB_BYTE), .NB_OPCODE(5)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        cyc();
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = '0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    task automatic start();
        bus.i_load_start = 1'b1;
        cyc();
        bus.i_load_start = 1'b0;
    endtask

    task automatic fetch(input logic [2:0] a);
        bus.i_enable = 1'b1;
        bus.i_addr   = a;
        cyc();
        bus.i_enable = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic ld, input logic [3:0] len,
                              input logic ovf);
        chk({tag, "_loaded"},   32'(bus.o_loaded),   32'(ld));
        chk({tag, "_prog_len"}, 32'(bus.o_prog_len), 32'(len));
        chk({tag, "_overflow"}, 32'(bus.o_overflow), 32'(ovf));
    endtask

    task automatic chk_fetch(input string tag, input logic [2:0] a, input logic [15:0] exp_d,
                             input logic exp_v);
        fetch(a);
        chk({tag, "_data"},  32'(bus.o_data),       32'(exp_d));
        chk({tag, "_valid"}, 32'(bus.o_data_valid), 32'(exp_v));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_reset          = 1'b0;
        bus.i_enable     = 1'b0;
        bus.i_addr       = '0;
        bus.i_load_start = 1'b0;
        bus.i_byte       = '0;
        bus.i_byte_valid = 1'b0;

        // T1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            bus.i_enable     = 1'($urandom);
            bus.i_addr       = 3'($urandom);
            bus.i_load_start = 1'($urandom);
            bus.i_byte       = 8'($urandom);
            bus.i_byte_valid = 1'($urandom);
            cyc();
        end
        chk_status("t1_rst", 1'b0, 4'd0, 1'b0);
        chk("t1_rst_data",  32'(bus.o_data),       32'h0);
        chk("t1_rst_valid", 32'(bus.o_data_valid), 32'h0);
        bus.i_enable     = 1'b0;
        bus.i_load_start = 1'b0;
        bus.i_byte_valid = 1'b0;
        i_reset          = 1'b1;
        chk_fetch("t1_idle_fetch", 3'd0, 16'h0000, 1'b0);
        // bytes outside LOAD must not load a (halt) program
        send_word(16'h0000);
        chk_status("t1_idle_bytes", 1'b0, 4'd0, 1'b0);

        // T2: load + run
        start();
        send_word(16'h1001);
        send_word(16'h2802);
        chk_status("t2_mid", 1'b0, 4'd0, 1'b0);
        send_word(16'h0000);
        chk_status("t2_done", 1'b1, 4'd3, 1'b0);
        chk_fetch("t2_a1", 3'd1, 16'h2802, 1'b1);
        cyc();
        chk("t2_hold_data",  32'(bus.o_data),       32'h2802);
        chk("t2_hold_valid", 32'(bus.o_data_valid), 32'h0);
        chk_fetch("t2_a0", 3'd0, 16'h1001, 1'b1);
        chk_fetch("t2_a5", 3'd5, 16'h0000, 1'b1);

        // T5: reload from RUN, single halt word
        start();
        chk_status("t5_start", 1'b0, 4'd0, 1'b0);
        chk("t5_start_valid", 32'(bus.o_data_valid), 32'h0);
        send_word(16'h0034);
        chk_status("t5_done", 1'b1, 4'd1, 1'b0);
        chk_fetch("t5_a0", 3'd0, 16'h0034, 1'b1);
        chk_fetch("t5_a1", 3'd1, 16'h0000, 1'b1);

        // T3: restart mid-word, byte coincident with start is dropped
        start();
        send_word(16'h1105);
        send_byte(8'h07);
        bus.i_byte       = 8'hAA;
        bus.i_byte_valid = 1'b1;
        bus.i_load_start = 1'b1;
        cyc();
        bus.i_byte_valid = 1'b0;
        bus.i_load_start = 1'b0;
        send_word(16'h1002);
        send_word(16'h0000);
        chk_status("t3_done", 1'b1, 4'd2, 1'b0);
        chk_fetch("t3_a0", 3'd0, 16'h1002, 1'b1);
        chk_fetch("t3_a1", 3'd1, 16'h0000, 1'b1);

        // T4: overflow, 8 non-halt words
        start();
        for (int k = 0; k < 7; k++) send_word(16'h0800 | 16'(k));
        chk_status("t4_7words", 1'b0, 4'd0, 1'b0);
        send_word(16'h0807);
        chk_status("t4_ovf", 1'b0, 4'd8, 1'b1);
        chk_fetch("t4_fetch", 3'd2, 16'h0000, 1'b0);
        send_word(16'h0000);
        chk_status("t4_ovf_sticky", 1'b0, 4'd8, 1'b1);

        // T4b: halt word in the last slot is a valid full program
        start();
        chk_status("t4b_start", 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 7; k++) send_word(16'h0810 | 16'(k));
        send_word(16'h0000);
        chk_status("t4b_full", 1'b1, 4'd8, 1'b0);
        chk_fetch("t4b_a6", 3'd6, 16'h0816, 1'b1);
        chk_fetch("t4b_a7", 3'd7, 16'h0000, 1'b1);

        // T6: reset mid-load
        start();
        send_word(16'h0811);
        send_byte(8'h22);
        i_reset = 1'b0;
        cyc();
        chk_status("t6_rst", 1'b0, 4'd0, 1'b0);
        chk("t6_rst_valid", 32'(bus.o_data_valid), 32'h0);
        i_reset = 1'b1;
        send_word(16'h0000);
        chk_status("t6_ignored", 1'b0, 4'd0, 1'b0);
        start();
        send_word(16'h0056);
        chk_status("t6_reload", 1'b1, 4'd1, 1'b0);
        chk_fetch("t6_a0", 3'd0, 16'h0056, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
